mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single main-memory port between the instruction-cache miss path and the data-cache miss path of the simple processor. Sits between both caches and the block-wide main memory, serialising block reads and writes and forwarding the memory busywait handshake to whichever cache is being served. Data requests have fixed priority over instruction fetches unless round-robin is compiled in.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, grant encoding,
// default port widths.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE_I,
    RELEASE_D
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between instruction and data requesters.
// MEM_ARB_ROUND_ROBIN_EN: on a tie, grant whoever was not served last;
// otherwise data always beats instruction.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_d,
  output logic gnt_vld,
  output gnt_e gnt
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // last-served only matters for round-robin
  logic unused_last;
  assign unused_last = last_d;
`endif

  // pick a winner whenever anyone is asking
  always_comb begin
    gnt_vld = i_req | d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    gnt = (d_req && !(i_req && last_d)) ? GNT_D : GNT_I;
`else
    gnt = d_req ? GNT_D : GNT_I;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the block-wide main-memory port between the I-cache and D-cache
// miss paths. One transaction at a time; the command is latched at grant
// and held until memory completes (busywait seen high, then low).
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin on ties).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  state_e state, nstate;
  logic   d_req, gnt_vld, last_d, seen_busy, done;
  gnt_e   gnt;

  assign d_req = d_read | d_write;
  // memory finished: it has been busy at least once and has now dropped
  assign done  = seen_busy & ~mem_busywait;

  mem_arb_pick u_pick (
    .i_req  (i_read),
    .d_req  (d_req),
    .last_d (last_d),
    .gnt_vld(gnt_vld),
    .gnt    (gnt)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // remember who won the most recent grant
  always_ff @(posedge CLK) begin
    if (RESET)                       last_d <= 1'b0;
    else if (state == IDLE && gnt_vld) last_d <= (gnt == GNT_D);
  end
`else
  assign last_d = 1'b0;
`endif

  // stall whoever is asking, except during its one-cycle release
  assign i_busywait = i_read && (state != RELEASE_I);
  assign d_busywait = d_req  && (state != RELEASE_D);

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= nstate;
  end

  // next-state logic
  always_comb begin
    nstate = state;
    case (state)
      IDLE:      if (gnt_vld) nstate = (gnt == GNT_D) ? SERVE_D : SERVE_I;
      SERVE_I:   if (done) nstate = RELEASE_I;
      SERVE_D:   if (done) nstate = RELEASE_D;
      RELEASE_I: nstate = IDLE;
      RELEASE_D: nstate = IDLE;
      default:   nstate = IDLE;
    endcase
  end

  // latched memory command, busy tracking and returned blocks
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      seen_busy     <= 1'b0;
      i_readdata    <= '0;
      d_readdata    <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          seen_busy <= 1'b0;
          if (gnt == GNT_D) begin
            // read+write together: write-back goes first, read is re-issued later
            mem_address   <= d_address;
            mem_writedata <= d_writedata;
            mem_write     <= d_write;
            mem_read      <= d_read & ~d_write;
          end else begin
            mem_address <= i_address;
            mem_write   <= 1'b0;
            mem_read    <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_busywait) seen_busy <= 1'b1;
          if (done) begin
            seen_busy <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) begin
              if (state == SERVE_I) i_readdata <= mem_readdata;
              else                  d_readdata <= mem_readdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: fixed-latency memory (busy 5 cycles from
// strobe), transaction-level reference model, directed cases plus random
// requesters.
module tb_mem_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 128;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] i_address = '0, d_address = '0;
  logic [DW-1:0] d_writedata = '0;
  logic [DW-1:0] i_readdata, d_readdata, mem_writedata, mem_readdata;
  logic          i_busywait, d_busywait, mem_read, mem_write, mem_busywait;
  logic [AW-1:0] mem_address;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  mem_port_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] pat(input int a);
    logic [7:0] b;
    b = {4'hA, a[3:0]};
    return {16{b}};
  endfunction

  // memory: busy from the cycle the strobe appears, for 5 edges; write lands on the 5th
  logic [DW-1:0] mem [64];
  bit            minit = 1'b0;
  int            mcnt = 0;
  assign mem_busywait = (mem_read || mem_write) && (mcnt < 5);
  assign mem_readdata = mem[mem_address];
  always @(posedge CLK) begin
    if (!minit) begin
      for (int a = 0; a < 64; a++) mem[a] <= pat(a);
      minit <= 1'b1;
    end else if (!RESET && mem_write && mcnt == 4) mem[mem_address] <= mem_writedata;
    if (RESET || !(mem_read || mem_write)) mcnt <= 0;
    else if (mcnt < 5) mcnt <= mcnt + 1;
  end

  // reference model: a transaction occupies edges grant..grant+7; strobes for
  // t=0..5 cycles after grant, release cycle at t=6, idle edge follows
  int            own = 0;   // 0 none, 1 I, 2 D
  int            mt = 0;
  logic          mw = 1'b0;
  logic [AW-1:0] ma = '0;
  logic [DW-1:0] mwd = '0, ird = '0, drd = '0;
  logic [DW-1:0] rmem [64];
  bit            rinit = 1'b0;
  logic          m_win_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic          m_last_d = 1'b0;
  assign m_win_d = (d_read || d_write) && !(i_read && m_last_d);
`else
  assign m_win_d = d_read || d_write;
`endif

  always @(posedge CLK) begin
    if (!rinit) begin
      for (int a = 0; a < 64; a++) rmem[a] <= pat(a);
      rinit <= 1'b1;
    end
    if (RESET) begin
      own <= 0; mt <= 0; ird <= '0; drd <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      m_last_d <= 1'b0;
`endif
    end else if (own != 0) begin
      mt <= mt + 1;
      if (mt == 4 && mw) rmem[ma] <= mwd;
      if (mt == 5 && !mw) begin
        if (own == 1) ird <= rmem[ma];
        else          drd <= rmem[ma];
      end
      if (mt == 6) own <= 0;
    end else if (i_read || d_read || d_write) begin
      mt <= 0;
      if (m_win_d) begin
        own <= 2; mw <= d_write; ma <= d_address; mwd <= d_writedata;
      end else begin
        own <= 1; mw <= 1'b0; ma <= i_address;
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      m_last_d <= m_win_d;
`endif
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // per-cycle comparison of every output against the model
  task automatic compare();
    bit srv;
    srv = (own != 0) && (mt <= 5);
    chk("mem_read",   DW'(mem_read),   DW'(srv && !mw));
    chk("mem_write",  DW'(mem_write),  DW'(srv && mw));
    if (srv) chk("mem_address", DW'(mem_address), DW'(ma));
    if (srv && mw) chk("mem_writedata", mem_writedata, mwd);
    chk("i_busywait", DW'(i_busywait), DW'(i_read && !(own == 1 && mt == 6)));
    chk("d_busywait", DW'(d_busywait), DW'((d_read || d_write) && !(own == 2 && mt == 6)));
    chk("i_readdata", i_readdata, ird);
    chk("d_readdata", d_readdata, drd);
  endtask

  task automatic step();
    @(negedge CLK);
    if (chk_en) compare();
    @(posedge CLK);
    #1;
  endtask

  // drop each request on its release cycle; stop when nobody is asking
  task automatic run_until_idle(input int bound, output int n);
    n = 0;
    while ((i_read || d_read || d_write) && n < bound) begin
      step();
      n++;
      if (i_read && !i_busywait) i_read = 1'b0;
      if ((d_read || d_write) && !d_busywait) begin d_read = 1'b0; d_write = 1'b0; end
    end
    if (i_read || d_read || d_write) begin
      total++; bad++;
      $display("FAIL timeout got=%0d want=<%0d", n, bound);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
  endtask

  initial begin
    int n;
    logic [AW-1:0] exp_a;

    // reset values
    step(); step();
    chk_en = 1'b1;
    step();
    chk("rst_mem_read", DW'(mem_read), '0);
    chk("rst_mem_write", DW'(mem_write), '0);
    chk("rst_mem_address", DW'(mem_address), '0);
    chk("rst_mem_writedata", mem_writedata, '0);
    chk("rst_i_readdata", i_readdata, '0);
    chk("rst_d_readdata", d_readdata, '0);
    RESET = 1'b0;
    step();

    // single instruction read: 8 edges grant to idle
    i_read = 1'b1; i_address = 6'h05;
    step();
    chk("i_first_read", DW'(mem_read), DW'(1'b1));
    chk("i_first_addr", DW'(mem_address), DW'(6'h05));
    run_until_idle(40, n);
    chk("i_latency_edges", DW'(n + 2), DW'(8));
    chk("i_readdata_a5", i_readdata, {16{8'hA5}});
    step();

    // data write-back
    d_write = 1'b1; d_address = 6'h10; d_writedata = 128'h1234;
    step();
    chk("dw_strobe", DW'(mem_write), DW'(1'b1));
    chk("dw_addr", DW'(mem_address), DW'(6'h10));
    chk("dw_data", mem_writedata, 128'h1234);
    run_until_idle(40, n);
    step();
    chk("dw_mem", mem[16], 128'h1234);
    chk("dw_readdata_kept", d_readdata, '0);

    // simultaneous requests; last served was D
    i_read = 1'b1; i_address = 6'h01; d_read = 1'b1; d_address = 6'h03;
    step();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_a = 6'h01;
`else
    exp_a = 6'h03;
`endif
    chk("tie_winner_addr", DW'(mem_address), DW'(exp_a));
    chk("tie_loser_stall", DW'(i_busywait && d_busywait), DW'(1'b1));
    run_until_idle(60, n);
    chk("tie_i_data", i_readdata, {16{8'hA1}});
    chk("tie_d_data", d_readdata, {16{8'hA3}});
    step();

    // read+write together: write only
    d_read = 1'b1; d_write = 1'b1; d_address = 6'h02; d_writedata = 128'hBEEF;
    step();
    chk("rw_write", DW'(mem_write), DW'(1'b1));
    chk("rw_no_read", DW'(mem_read), '0);
    run_until_idle(40, n);
    step();
    chk("rw_mem", mem[2], 128'hBEEF);

    // reset in the middle of a data read
    d_read = 1'b1; d_address = 6'h07;
    step(); step(); step();
    RESET = 1'b1; d_read = 1'b0;
    step();
    chk("mrst_strobe", DW'(mem_read), '0);
    chk("mrst_i_rd", i_readdata, '0);
    chk("mrst_d_rd", d_readdata, '0);
    RESET = 1'b0;
    i_read = 1'b1; i_address = 6'h05;
    run_until_idle(40, n);
    chk("mrst_after_i", i_readdata, {16{8'hA5}});
    step();

    // address changes while being served
    i_read = 1'b1; i_address = 6'h09;
    step();
    i_address = 6'h03;
    step(); step();
    chk("latched_addr", DW'(mem_address), DW'(6'h09));
    run_until_idle(40, n);
    chk("latched_data", i_readdata, {16{8'hA9}});
    step();

    // random requesters, occasional reset
    for (int c = 0; c < 3000; c++) begin
      step();
      if (i_read && !i_busywait) i_read = 1'b0;
      if ((d_read || d_write) && !d_busywait) begin d_read = 1'b0; d_write = 1'b0; end
      if (!i_read) begin
        if ($urandom_range(0, 2) == 0) begin i_read = 1'b1; i_address = 6'($urandom); end
      end else if ($urandom_range(0, 5) == 0) i_address = 6'($urandom);
      if (!(d_read || d_write)) begin
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 4))
            0, 1:    d_read = 1'b1;
            2, 3:    d_write = 1'b1;
            default: begin d_read = 1'b1; d_write = 1'b1; end
          endcase
          d_address = 6'($urandom);
          d_writedata = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if ($urandom_range(0, 5) == 0) begin
        d_address = 6'($urandom);
        d_writedata = {$urandom, $urandom, $urandom, $urandom};
      end
      RESET = ($urandom_range(0, 199) == 0);
    end
    RESET = 1'b0;
    run_until_idle(100, n);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
